// File: rtl/sujanreddy_synapse.sv
// 4x4 synapse crossbar feeding four LIF neurons, pin-programmable tile.
// Define SYNAPSE_STDP_EN to enable on-chip spike-driven weight learning.
module sujanreddy_synapse (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    M_RUN   = 2'b00,
    M_WRITE = 2'b01,
    M_CFG   = 2'b10,
    M_READ  = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(ui_in[7:6]);

  logic [3:0] w_q [4][4];
  logic [3:0] w_d [4][4];
  logic [7:0] v_q [4];
  logic [7:0] v_d [4];
  logic [7:0] thr_q, thr_d;
  logic [1:0] leak_q, leak_d;
  logic [3:0] spk_q, spk_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] s;
  logic [5:0] sum [4];
  logic [7:0] nxt [4];
  logic [3:0] fire;

  logic unused_ena;
  assign unused_ena = ena;
  assign s = ui_in[3:0];

  // Integration path, saturated at 255 before the threshold compare.
  always_comb begin
    logic [7:0] lk;
    logic [9:0] raw;
    fire = '0;
    for (int j = 0; j < 4; j++) begin
      sum[j] = '0;
      for (int i = 0; i < 4; i++)
        if (s[i]) sum[j] = sum[j] + {2'b00, w_q[i][j]};
      lk  = (leak_q == 2'd0) ? 8'd0 : (v_q[j] >> leak_q);
      raw = {2'b00, v_q[j]} - {2'b00, lk} + {4'b0000, sum[j]};
      nxt[j]  = (raw > 10'd255) ? 8'hff : raw[7:0];
      fire[j] = (nxt[j] >= thr_q);
    end
  end

  always_comb begin
    w_d    = w_q;
    v_d    = v_q;
    thr_d  = thr_q;
    leak_d = leak_q;
    spk_d  = '0;
    cnt_d  = cnt_q;
    unique case (1'b1)
      (mode == M_RUN): begin
        for (int j = 0; j < 4; j++) begin
          spk_d[j] = fire[j];
          v_d[j]   = fire[j] ? 8'd0 : nxt[j];
        end
        cnt_d = cnt_q + {3'b000, fire[0]} + {3'b000, fire[1]}
              + {3'b000, fire[2]} + {3'b000, fire[3]};
`ifdef SYNAPSE_STDP_EN
        if (ui_in[4]) begin
          for (int j = 0; j < 4; j++)
            if (fire[j])
              for (int i = 0; i < 4; i++)
                if (s[i])
                  w_d[i][j] = (w_q[i][j] == 4'hf) ? 4'hf : w_q[i][j] + 4'd1;
                else
                  w_d[i][j] = (w_q[i][j] == 4'h0) ? 4'h0 : w_q[i][j] - 4'd1;
        end
`endif
      end
      (mode == M_WRITE): w_d[ui_in[5:4]][ui_in[3:2]] = uio_in[3:0];
      (mode == M_CFG): begin
        thr_d  = uio_in;
        leak_d = ui_in[1:0];
      end
      (mode == M_READ): ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        v_q[i] <= '0;
        for (int j = 0; j < 4; j++) w_q[i][j] <= '0;
      end
      thr_q  <= 8'd16;
      leak_q <= '0;
      spk_q  <= '0;
      cnt_q  <= '0;
    end else begin
      w_q    <= w_d;
      v_q    <= v_d;
      thr_q  <= thr_d;
      leak_q <= leak_d;
      spk_q  <= spk_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    uo_out = {cnt_q, spk_q};
    if (mode == M_READ) begin
      unique case (ui_in[5:4])
        2'b00: uo_out = v_q[ui_in[1:0]];
        2'b01: uo_out = {4'b0000, w_q[ui_in[3:2]][ui_in[1:0]]};
        2'b10: uo_out = thr_q;
        2'b11: uo_out = {6'b000000, leak_q};
        default: uo_out = '0;
      endcase
    end
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_sujanreddy_synapse.sv
// Directed bench for the synapse tile: readback, integration, leak,
// saturation, async reset and optional learning.
module tb_sujanreddy_synapse;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk;
  int n_pass;

  sujanreddy_synapse dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h want 0x%02h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] sel,
                       input logic [1:0] a, input logic [1:0] b,
                       input logic [7:0] exp);
    logic [7:0] save;
    save  = ui_in;
    ui_in = {2'b11, sel, a, b};
    #1;
    chk(tag, uo_out, exp);
    ui_in = save;
    #1;
  endtask

  task automatic wr(input logic [1:0] i, input logic [1:0] j,
                    input logic [3:0] val);
    ui_in  = {2'b01, i, j, 2'b00};
    uio_in = {4'h0, val};
    step();
  endtask

  task automatic cfg(input logic [7:0] thr, input logic [1:0] lk);
    ui_in  = {2'b10, 4'h0, lk};
    uio_in = thr;
    step();
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] vexp [6];
    logic [7:0] w00_exp, w10_exp;
    n_chk  = 0;
    n_pass = 0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;
    #12;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    rdchk("rst_thr", 2'b10, 2'd0, 2'd0, 8'd16);
    rdchk("rst_w23", 2'b01, 2'd2, 2'd3, 8'd0);
    rdchk("rst_v1", 2'b00, 2'd0, 2'd1, 8'd0);
    rdchk("rst_leak", 2'b11, 2'd0, 2'd0, 8'd0);
    rst_n = 1'b1;

    // Basic integrate and fire
    wr(2'd0, 2'd0, 4'd5);
    cfg(8'd10, 2'd0);
    rdchk("t1_thr", 2'b10, 2'd0, 2'd0, 8'd10);
    rdchk("t1_w00", 2'b01, 2'd0, 2'd0, 8'd5);
    ui_in = 8'h01;
    step();
    rdchk("t1_v0_e1", 2'b00, 2'd0, 2'd0, 8'd5);
    chk("t1_uo_e1", uo_out, 8'h00);
    step();
    chk("t1_uo_e2", uo_out, 8'h11);
    rdchk("t1_v0_e2", 2'b00, 2'd0, 2'd0, 8'd0);
    step();
    chk("t1_uo_e3", uo_out, 8'h10);

    // Leak reaches a steady state below threshold
    pulse_rst();
    wr(2'd0, 2'd0, 4'd4);
    cfg(8'd200, 2'd1);
    rdchk("t2_leak", 2'b11, 2'd0, 2'd0, 8'd1);
    vexp = '{8'd4, 8'd6, 8'd7, 8'd8, 8'd8, 8'd8};
    ui_in = 8'h01;
    for (int k = 0; k < 6; k++) begin
      step();
      rdchk($sformatf("t2_v0_e%0d", k + 1), 2'b00, 2'd0, 2'd0, vexp[k]);
      chk($sformatf("t2_uo_e%0d", k + 1), uo_out, 8'h00);
    end

    // Full weights, saturation at 255
    pulse_rst();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        wr(2'(i), 2'(j), 4'hf);
    cfg(8'd255, 2'd0);
    ui_in = 8'h0f;
    for (int k = 1; k <= 4; k++) begin
      step();
      rdchk($sformatf("t3_v0_e%0d", k), 2'b00, 2'd0, 2'd0, 8'(60 * k));
      rdchk($sformatf("t3_v3_e%0d", k), 2'b00, 2'd0, 2'd3, 8'(60 * k));
      chk($sformatf("t3_uo_e%0d", k), uo_out, 8'h00);
    end
    step();
    chk("t3_uo_e5", uo_out, 8'h4f);
    rdchk("t3_v2_e5", 2'b00, 2'd0, 2'd2, 8'd0);

    // Async reset with live potential and spikes
    pulse_rst();
    wr(2'd0, 2'd0, 4'd5);
    wr(2'd0, 2'd1, 4'd15);
    cfg(8'd10, 2'd0);
    ui_in = 8'h01;
    step();
    chk("t4_uo_pre", uo_out, 8'h12);
    rdchk("t4_v0_pre", 2'b00, 2'd0, 2'd0, 8'd5);
    rst_n = 1'b0;
    #1;
    chk("t4_uo_rst", uo_out, 8'h00);
    rdchk("t4_v0_rst", 2'b00, 2'd0, 2'd0, 8'd0);
    rdchk("t4_thr_rst", 2'b10, 2'd0, 2'd0, 8'd16);
    rst_n = 1'b1;
    #1;

    // Learning on a firing edge
    pulse_rst();
    wr(2'd0, 2'd0, 4'd10);
    wr(2'd1, 2'd0, 4'd10);
    cfg(8'd10, 2'd0);
    ui_in = 8'h11;
    step();
    chk("t5_uo", uo_out, 8'h11);
`ifdef SYNAPSE_STDP_EN
    w00_exp = 8'd11;
    w10_exp = 8'd9;
`else
    w00_exp = 8'd10;
    w10_exp = 8'd10;
`endif
    ui_in = 8'hc0;
    rdchk("t5_w00", 2'b01, 2'd0, 2'd0, w00_exp);
    rdchk("t5_w10", 2'b01, 2'd1, 2'd0, w10_exp);
    rdchk("t5_w20", 2'b01, 2'd2, 2'd0, 8'd0);
    rdchk("t5_w01", 2'b01, 2'd0, 2'd1, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
